// File: rtl/slot_game_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : slot_pkg                                                    |
// | Shared types and default game constants for the slot-machine game    |
// | logic and the display's credit digit decoder.                        |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package slot_pkg;

  // Game phases; the SPIN_* names say which reels are still turning.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPIN_ALL = 3'd1,
    SPIN_2   = 3'd2,
    SPIN_1   = 3'd3,
    EVAL     = 3'd4
  } state_t;

  typedef logic [1:0] symbol_t;
  typedef logic [9:0] credit_t;

  localparam credit_t    C_BET         = 10'd10;
  localparam credit_t    C_COIN_VALUE  = 10'd10;
  localparam credit_t    C_INIT_CREDIT = 10'd100;
  localparam credit_t    C_MAX_CREDIT  = 10'd999;
  localparam logic [7:0] C_SPIN_FRAMES    = 8'd60;
  localparam logic [7:0] C_STAGGER_FRAMES = 8'd20;
  localparam credit_t    C_PAY_TRIPLE  = 10'd50;
  localparam credit_t    C_PAY_JACKPOT = 10'd100;

  // Clamp an 11-bit intermediate balance to the display ceiling.
  function automatic credit_t sat_credit(input logic [10:0] sum, input credit_t ceiling);
    if (sum > {1'b0, ceiling}) begin
      return ceiling;
    end
    return sum[9:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/slot_game_ctrl_btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : btn_edge                                                    |
// | Registered rising-edge detector for an already-synchronized button   |
// | level. One press yields one 1-cycle pulse, however long it is held.  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;
  logic rise_q;

  // Remember the previous level and register the rise so the event is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_i;
      rise_q  <= level_i & ~level_q;
    end
  end

  assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/slot_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : slot_game_ctrl                                              |
// | Slot-machine game logic: button events, spin/stop/evaluate sequence, |
// | per-frame reel advance and saturating credit balance.                |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter credit_t    BET            = C_BET,
  parameter credit_t    COIN_VALUE     = C_COIN_VALUE,
  parameter credit_t    INIT_CREDIT    = C_INIT_CREDIT,
  parameter credit_t    MAX_CREDIT     = C_MAX_CREDIT,
  parameter logic [7:0] SPIN_FRAMES    = C_SPIN_FRAMES,
  parameter logic [7:0] STAGGER_FRAMES = C_STAGGER_FRAMES,
  parameter credit_t    PAY_TRIPLE     = C_PAY_TRIPLE,
  parameter credit_t    PAY_JACKPOT    = C_PAY_JACKPOT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_coin,
  input  logic       btn_spin,
  input  logic       btn_stop,
  output logic [1:0] reel_pos0,
  output logic [1:0] reel_pos1,
  output logic [1:0] reel_pos2,
  output logic [9:0] credit,
  output logic       stop,
  output logic       spinning,
  output logic       win,
  output logic       reject
);

  logic w_coin_ev;
  logic w_spin_ev;
  logic w_stop_ev;

  btn_edge u_coin_edge (.clk(clk), .rst(rst), .level_i(btn_coin), .rise_o(w_coin_ev));
  btn_edge u_spin_edge (.clk(clk), .rst(rst), .level_i(btn_spin), .rise_o(w_spin_ev));
  btn_edge u_stop_edge (.clk(clk), .rst(rst), .level_i(btn_stop), .rise_o(w_stop_ev));

  state_t         state_q, state_d;
  logic [7:0]     fcnt_q, fcnt_d;
  symbol_t [2:0]  pos_q, pos_d;
  credit_t        credit_q, credit_d;
  logic           stop_q, stop_d;
  logic           win_q, win_d;
  logic           reject_q, reject_d;

  logic [2:0]     w_mask;
  logic [7:0]     w_limit;
  state_t         w_next_phase;
  logic           w_exit;
  logic           w_match;
  logic [10:0]    w_add;
  logic [10:0]    w_sub;
  logic [10:0]    w_sum;

  assign w_match = (pos_q[0] == pos_q[1]) && (pos_q[1] == pos_q[2]);

  // Per-phase view: which reels still turn, their frame limit, and where the phase exits to.
  always_comb begin
    w_mask       = 3'b000;
    w_limit      = STAGGER_FRAMES;
    w_next_phase = IDLE;
    case (state_q)
      SPIN_ALL: begin
        w_mask       = 3'b111;
        w_limit      = SPIN_FRAMES;
        w_next_phase = SPIN_2;
      end
      SPIN_2: begin
        w_mask       = 3'b110;
        w_next_phase = SPIN_1;
      end
      SPIN_1: begin
        w_mask       = 3'b100;
        w_next_phase = EVAL;
      end
      default: begin
        w_mask       = 3'b000;
      end
    endcase
  end

  // Next-state, reel advance and credit arithmetic; a coin is credited in every state.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    pos_d    = pos_q;
    win_d    = 1'b0;
    reject_d = 1'b0;
    w_exit   = 1'b0;
    w_add    = w_coin_ev ? {1'b0, COIN_VALUE} : 11'd0;
    w_sub    = 11'd0;

    case (state_q)
      IDLE: begin
        if (w_spin_ev) begin
          // Affordability uses the balance before any coin in this same cycle.
          if (credit_q >= BET) begin
            w_sub   = {1'b0, BET};
            fcnt_d  = 8'd0;
            state_d = SPIN_ALL;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      SPIN_ALL, SPIN_2, SPIN_1: begin
        // The tick's advance is always applied; a coincident stop still exits only one phase.
        if (frame_tick) begin
          for (int i = 0; i < 3; i++) begin
            if (w_mask[i]) begin
              pos_d[i] = pos_q[i] + 2'd1;
            end
          end
          fcnt_d = fcnt_q + 8'd1;
          if ((fcnt_q + 8'd1) == w_limit) begin
            w_exit = 1'b1;
          end
        end
        if (w_stop_ev) begin
          w_exit = 1'b1;
        end
        if (w_exit) begin
          fcnt_d  = 8'd0;
          state_d = w_next_phase;
        end
      end
      EVAL: begin
        state_d = IDLE;
        if (w_match) begin
          win_d = 1'b1;
          w_add = w_add + ((pos_q[0] == 2'd3) ? {1'b0, PAY_JACKPOT} : {1'b0, PAY_TRIPLE});
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    w_sum    = {1'b0, credit_q} + w_add - w_sub;
    credit_d = sat_credit(w_sum, MAX_CREDIT);
    stop_d   = (state_d == IDLE) || (state_d == EVAL);
  end

  // State and registered outputs; reset may arrive asynchronously mid-spin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fcnt_q   <= 8'd0;
      pos_q    <= '0;
      credit_q <= INIT_CREDIT;
      stop_q   <= 1'b1;
      win_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      pos_q    <= pos_d;
      credit_q <= credit_d;
      stop_q   <= stop_d;
      win_q    <= win_d;
      reject_q <= reject_d;
    end
  end

  assign reel_pos0 = pos_q[0];
  assign reel_pos1 = pos_q[1];
  assign reel_pos2 = pos_q[2];
  assign credit    = credit_q;
  assign stop      = stop_q;
  assign spinning  = ~stop_q;
  assign win       = win_q;
  assign reject    = reject_q;

endmodule
`default_nettype wire

// File: tb/tb_slot_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_slot_game_ctrl                                           |
// | Four parameterizations of slot_game_ctrl driven by common inputs and |
// | compared every cycle against a behavioural game model.               |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_slot_game_ctrl;

  localparam int ND    = 4;
  localparam int BET   = 10;
  localparam int COIN  = 10;
  localparam int MAXC  = 999;
  localparam int PT    = 50;
  localparam int PJ    = 100;
  localparam int SPINF = 4;

  logic clk;
  logic rst;
  logic frame_tick;
  logic btn_coin;
  logic btn_spin;
  logic btn_stop;

  logic [ND-1:0][1:0] rp0, rp1, rp2;
  logic [ND-1:0][9:0] cr;
  logic [ND-1:0]      st, sp, wn, rj;

  // DUT 0: stagger 2, credit 100; DUT 1: stagger 4, credit 100; DUT 2: credit 5; DUT 3: credit 995.
  for (genvar g = 0; g < ND; g++) begin : g_dut
    slot_game_ctrl #(
      .SPIN_FRAMES   (8'd4),
      .STAGGER_FRAMES((g == 0) ? 8'd2 : 8'd4),
      .INIT_CREDIT   ((g == 2) ? 10'd5 : ((g == 3) ? 10'd995 : 10'd100))
    ) u_dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .btn_coin(btn_coin), .btn_spin(btn_spin), .btn_stop(btn_stop),
      .reel_pos0(rp0[g]), .reel_pos1(rp1[g]), .reel_pos2(rp2[g]),
      .credit(cr[g]), .stop(st[g]), .spinning(sp[g]), .win(wn[g]), .reject(rj[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;

  // Behavioural model: mode 0 idle, 1 reels turning (m_n of them, rightmost last), 2 evaluate.
  int m_mode [ND];
  int m_n    [ND];
  int m_fcnt [ND];
  int m_pos  [ND][3];
  int m_cr   [ND];
  int m_win  [ND];
  int m_rej  [ND];
  bit ev_coin, ev_spin, ev_stop, pv_coin, pv_spin, pv_stop;
  bit r_coin, r_spin, r_stop, r_tick;

  function automatic int stagger_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int init_of(input int d);
    return (d == 2) ? 5 : ((d == 3) ? 995 : 100);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_mode[d] = 0; m_n[d] = 0; m_fcnt[d] = 0;
      for (int r = 0; r < 3; r++) m_pos[d][r] = 0;
      m_cr[d] = init_of(d); m_win[d] = 0; m_rej[d] = 0;
    end
    ev_coin = 0; ev_spin = 0; ev_stop = 0;
    pv_coin = 0; pv_spin = 0; pv_stop = 0;
  endtask

  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      int add;
      int sub;
      int lim;
      bit ex;
      add = 0; sub = 0; ex = 0;
      m_win[d] = 0; m_rej[d] = 0;
      if (ev_coin) add += COIN;
      case (m_mode[d])
        0: begin
          if (ev_spin) begin
            if (m_cr[d] >= BET) begin
              sub = BET; m_fcnt[d] = 0; m_mode[d] = 1; m_n[d] = 3;
            end else begin
              m_rej[d] = 1;
            end
          end
        end
        1: begin
          lim = (m_n[d] == 3) ? SPINF : stagger_of(d);
          if (frame_tick) begin
            for (int r = 3 - m_n[d]; r < 3; r++) m_pos[d][r] = (m_pos[d][r] + 1) % 4;
            m_fcnt[d]++;
            if (m_fcnt[d] == lim) ex = 1;
          end
          if (ev_stop) ex = 1;
          if (ex) begin
            m_fcnt[d] = 0;
            m_n[d]--;
            if (m_n[d] == 0) m_mode[d] = 2;
          end
        end
        default: begin
          if (m_pos[d][0] == m_pos[d][1] && m_pos[d][1] == m_pos[d][2]) begin
            add += (m_pos[d][0] == 3) ? PJ : PT;
            m_win[d] = 1;
          end
          m_mode[d] = 0;
        end
      endcase
      m_cr[d] = m_cr[d] + add - sub;
      if (m_cr[d] > MAXC) m_cr[d] = MAXC;
    end
    ev_coin = btn_coin && !pv_coin;
    ev_spin = btn_spin && !pv_spin;
    ev_stop = btn_stop && !pv_stop;
    pv_coin = btn_coin; pv_spin = btn_spin; pv_stop = btn_stop;
  endtask

  function automatic logic [19:0] exp_vec(input int d);
    return {2'(m_pos[d][0]), 2'(m_pos[d][1]), 2'(m_pos[d][2]), 10'(m_cr[d]),
            (m_mode[d] != 1), (m_mode[d] == 1), 1'(m_win[d]), 1'(m_rej[d])};
  endfunction

  function automatic logic [19:0] obs_vec(input int d);
    return {rp0[d], rp1[d], rp2[d], cr[d], st[d], sp[d], wn[d], rj[d]};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_dut%0d_cyc%0d", tag, d, cyc), 32'(obs_vec(d)), 32'(exp_vec(d)));
    end
  endtask

  task automatic step(input bit t, input bit c, input bit s, input bit p, input string tag);
    frame_tick = t; btn_coin = c; btn_spin = s; btn_stop = p;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_all(tag);
  endtask

  // Reset asserted between clock edges; outputs must change before any edge.
  task automatic do_reset();
    frame_tick = 0; btn_coin = 0; btn_spin = 0; btn_stop = 0;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    #2;
    rst = 1'b0;
  endtask

  task automatic press_spin();
    step(0, 0, 1, 0, "spin_lvl");
    step(0, 0, 0, 0, "spin_ev");
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 0; btn_coin = 0; btn_spin = 0; btn_stop = 0;
    r_coin = 0; r_spin = 0; r_stop = 0; r_tick = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2;
    rst = 1'b0;

    // Free-running spin: bet deducted, reels auto-stop on frame counts.
    press_spin();
    check("s1_credit90", 32'(cr[0]), 32'd90);
    check("s1_reject_low", 32'(rj[2]), 32'd1);
    repeat (8) step(1, 0, 0, 0, "s1_tick");
    repeat (4) step(0, 0, 0, 0, "s1_idle");
    check("s1_pos", 32'({rp0[0], rp1[0], rp2[0]}), 32'({2'd0, 2'd2, 2'd0}));
    check("s1_credit", 32'(cr[0]), 32'd90);
    check("s1_stop", 32'(st[0]), 32'd1);
    repeat (4) step(1, 0, 0, 0, "s2_tick");
    repeat (3) step(0, 0, 0, 0, "s2_idle");
    check("s2_pos", 32'({rp0[1], rp1[1], rp2[1]}), 32'd0);
    check("s2_credit140", 32'(cr[1]), 32'd140);
    check("s2_low_credit", 32'(cr[2]), 32'd5);
    check("s2_sat", 32'(cr[3]), 32'd999);

    // Manual stops after three ticks land on the jackpot.
    do_reset();
    press_spin();
    repeat (3) step(1, 0, 0, 0, "s3_tick");
    repeat (3) begin
      step(0, 0, 0, 1, "s3_stop_lvl");
      step(0, 0, 0, 0, "s3_stop_ev");
    end
    step(0, 0, 0, 0, "s3_eval");
    check("s3_pos", 32'({rp0[0], rp1[0], rp2[0]}), 32'({2'd3, 2'd3, 2'd3}));
    check("s3_credit190", 32'(cr[0]), 32'd190);
    check("s3_win", 32'(wn[0]), 32'd1);

    // Stop coincident with a tick: one advance, one phase exit.
    do_reset();
    press_spin();
    step(1, 0, 0, 0, "s4_tick");
    step(0, 0, 0, 1, "s4_stop_lvl");
    step(1, 0, 0, 0, "s4_tick_stop");
    check("s4_pos", 32'({rp0[0], rp1[0], rp2[0]}), 32'({2'd2, 2'd2, 2'd2}));
    check("s4_still_spin", 32'(st[0]), 32'd0);
    repeat (2) step(1, 0, 0, 0, "s4_tick2");
    check("s4_pos2", 32'({rp0[0], rp1[0], rp2[0]}), 32'({2'd2, 2'd0, 2'd0}));
    repeat (4) step(1, 0, 0, 0, "s4_tail");

    // Low balance: reject, coin, then accepted spin.
    do_reset();
    press_spin();
    check("s5_reject", 32'(rj[2]), 32'd1);
    check("s5_cr5", 32'(cr[2]), 32'd5);
    step(0, 1, 0, 0, "s5_coin_lvl");
    step(0, 0, 0, 0, "s5_coin_ev");
    check("s5_cr15", 32'(cr[2]), 32'd15);
    press_spin();
    check("s5_cr5b", 32'(cr[2]), 32'd5);
    repeat (14) step(1, 0, 0, 0, "s5_tail");

    // Held coin counts once and saturates; then coin and payout together in EVAL.
    do_reset();
    repeat (20) step(0, 1, 0, 0, "s6_coin_hold");
    check("s6_cr999", 32'(cr[3]), 32'd999);
    step(0, 0, 0, 0, "s6_rel");
    press_spin();
    repeat (2) begin
      step(0, 0, 0, 1, "s6_stop_lvl");
      step(0, 0, 0, 0, "s6_stop_ev");
    end
    step(0, 0, 0, 1, "s6_stop_lvl3");
    step(0, 1, 0, 0, "s6_stop_ev3");
    step(0, 0, 0, 0, "s6_eval");
    check("s6_eval_win", 32'(wn[3]), 32'd1);
    check("s6_eval_sat", 32'(cr[3]), 32'd999);

    // Asynchronous reset while in the second phase.
    do_reset();
    press_spin();
    repeat (5) step(1, 0, 0, 0, "s7_tick");
    do_reset();
    check("s7_credit", 32'(cr[0]), 32'd100);
    check("s7_stop", 32'(st[0]), 32'd1);
    step(1, 0, 0, 1, "s7_after");
    step(1, 0, 0, 0, "s7_after2");
    check("s7_idle_pos", 32'({rp0[0], rp1[0], rp2[0]}), 32'd0);

    // Random play.
    for (int i = 0; i < 1500; i++) begin
      r_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) r_coin = ~r_coin;
      if ($urandom_range(0, 3) == 0)  r_spin = ~r_spin;
      if ($urandom_range(0, 4) == 0)  r_stop = ~r_stop;
      step(r_tick, r_coin, r_spin, r_stop, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slot_game_ctrl.md
Name: slot_game_ctrl

Overview:
Game-logic stage directly upstream of the VGA display controller in the slot-machine design. It debounces nothing but edge-detects three synchronized push-button levels (coin, spin, stop). It runs the spin/stop/evaluate state machine, advances three 2-bit reel positions once per video frame, and maintains a saturating credit balance. Its outputs drive the display's reel rotation states, its `stop` input and the 3-digit credit readout.

Parameters:
- BET, 10'd10: credits deducted per accepted spin
- COIN_VALUE, 10'd10: credits added per coin press
- INIT_CREDIT, 10'd100: credit after reset
- MAX_CREDIT, 10'd999: saturation ceiling, sized for the 3-digit display
- SPIN_FRAMES, 8'd60: frame ticks before reel 0 auto-stops
- STAGGER_FRAMES, 8'd20: frame ticks between auto-stops of successive reels
- PAY_TRIPLE, 10'd50: payout when all three reels match on symbol 0, 1 or 2
- PAY_JACKPOT, 10'd100: payout when all three reels equal 2'd3

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame, from the VGA controller (Q_Y==1 && Q_X==0)
- btn_coin  in  1  synchronized level, active-high
- btn_spin  in  1  synchronized level, active-high
- btn_stop  in  1  synchronized level, active-high
- reel_pos0, reel_pos1, reel_pos2  out  2 each  middle-row symbol index per reel
- credit  out  10  balance, 0..MAX_CREDIT
- stop  out  1  1 when no reel is spinning (IDLE or EVAL)
- spinning  out  1  ~stop
- win  out  1  one-cycle pulse on payout
- reject  out  1  one-cycle pulse when a spin is refused

Behaviour:
- Reset (async assert, any state, mid-spin included): state=IDLE, credit=INIT_CREDIT, all reel_pos=0, stop=1, win=0, reject=0, edge-detector history=0.
- Buttons: registered rising-edge detect. A press yields exactly one 1-cycle event regardless of hold length. Event is usable the cycle after the level rises.
- States: IDLE, SPIN_ALL, SPIN_2, SPIN_1, EVAL. 8-bit frame counter fcnt.
- IDLE:
  - spin event with credit>=BET: credit-=BET, fcnt=0, go to SPIN_ALL.
  - spin event with credit<BET: reject pulse, stay, credit unchanged.
- SPIN_ALL: each frame_tick advances all three reels (+1 mod 4, 3 wraps to 0) and increments fcnt. Exit to SPIN_2 when fcnt reaches SPIN_FRAMES on a tick, or on a stop event. Clear fcnt. Reel 0 freezes.
- SPIN_2: same rule with reels 1 and 2, limit STAGGER_FRAMES. Exit to SPIN_1; reel 1 freezes.
- SPIN_1: same rule with reel 2 only, limit STAGGER_FRAMES. Exit to EVAL; reel 2 freezes.
- Tick and stop event in the same cycle: the tick's advance is applied, then exactly one phase exit occurs (no double-stop).
- Stop event with no tick: freeze without advancing.
- EVAL (exactly one cycle), then IDLE:
  - pos0==pos1==pos2==3: add PAY_JACKPOT, win=1.
  - other three-way match: add PAY_TRIPLE, win=1.
  - otherwise: no change, win=0.
- Coin event is accepted in every state: credit=min(credit+COIN_VALUE, MAX_CREDIT).
- Coin and payout in the same EVAL cycle: both are added, then saturated once.
- Coin and accepted spin in the same IDLE cycle: net credit = min(credit+COIN_VALUE-BET, MAX); the spin check uses the pre-coin credit.
- Credit arithmetic is 11-bit internally; it never underflows or exceeds MAX_CREDIT.
- Spin events outside IDLE are ignored, with no reject pulse. Stop events in IDLE or EVAL are ignored.
- Outputs are registered. reel_pos changes one cycle after the triggering tick.

Decomposition:
- Package slot_pkg:
  - state enum (IDLE, SPIN_ALL, SPIN_2, SPIN_1, EVAL)
  - typedef symbol_t = logic[1:0]
  - typedef credit_t = logic[9:0]
  - default BET/COIN/payout constants, shared with the display's digit decoder
- Sub-module btn_edge: async-reset register plus rising-edge pulse. Instantiated three times.

Test Plan:
- Defaults except SPIN_FRAMES=4, STAGGER_FRAMES=2. Spin press, then 8 ticks with no stop presses:
  - credit 100 to 90 one cycle after the event
  - final positions 0,2,0, win never asserted, credit 90, stop=1 after EVAL
- SPIN_FRAMES=4, STAGGER_FRAMES=4, spin with no stop presses:
  - final positions 0,0,0, win pulse exactly one cycle, credit 140
- Spin, 3 ticks, then stop, stop, stop with no intervening ticks:
  - positions 3,3,3, jackpot, credit 190
  - a stop coincident with a tick advances once and exits one phase only
- INIT_CREDIT=5: spin gives a reject pulse and credit 5; coin gives 15; spin accepted and credit 5.
- INIT_CREDIT=995: coin held high 20 cycles gives credit 999 once.
  - with credit 999 in the win scenario, coin and payout in EVAL leave credit 999.
- Reset asserted during SPIN_2, asynchronously between clock edges: outputs immediately return to credit=INIT_CREDIT, positions 0, stop=1, and state is IDLE after release.
